// File: rtl/symm_ctrl.sv
// ---------------------------------------------------------------------------
// symm_ctrl
// Sequencer for the iterative symmetric orthogonalization loop
//    W <- 1.5W - 0.5*(W*W^T)*W
// Each iteration has four phases. MUL fires the 4x4 W*W^T multiplier.
// WAIT spends UPD_LAT cycles until the update register latches. CHECK
// counts the iteration and decides whether to loop or finish. DONE emits a
// one-cycle completion pulse.
//
// Optional feature:
//    SYMM_CTRL_CONV_EN - when defined, conv=1 in CHECK ends the run early.
//                        When undefined, conv is ignored and every run
//                        executes exactly iter_num iterations.
//
// Parameters:
//    ITER_W   width of the iteration-count fields
//    UPD_LAT  cycles spent in WAIT, 1..15
//
// Ports:
//    clk_sctl   in   sole clock, rising edge
//    rstn_sctl  in   asynchronous active-low reset
//    start      in   request a run, sampled in IDLE only
//    abort      in   terminate a run in progress (MUL/WAIT/CHECK)
//    iter_num   in   requested iteration count, captured at accepted start
//    conv       in   convergence flag, sampled in CHECK
//    en_mul4    out  multiplier enable, one cycle per iteration
//    sel_fb     out  multiplier source: 0 = external W, 1 = fed-back W
//    en_upd     out  update-register latch enable, last WAIT cycle
//    busy       out  high in every state except IDLE
//    done       out  single-cycle completion pulse
//    iter_cnt   out  completed iterations of current or last run
// ---------------------------------------------------------------------------
module symm_ctrl #(
   parameter int ITER_W  = 4,
   parameter int UPD_LAT = 2
) (
   input  logic              clk_sctl,
   input  logic              rstn_sctl,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] iter_num,
   input  logic              conv,
   output logic              en_mul4,
   output logic              sel_fb,
   output logic              en_upd,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      WAIT,
      CHECK,
      DONE
   } state_t;

   state_t            state, state_d;
   logic [ITER_W-1:0] cnt_d;
   logic [ITER_W-1:0] num_q, num_d;
   logic [3:0]        wait_cnt, wait_d;
   logic              sel_d;
   logic [ITER_W-1:0] cnt_inc;
   logic              conv_exit;

   assign cnt_inc = iter_cnt + ITER_W'(1);

`ifdef SYMM_CTRL_CONV_EN
   assign conv_exit = conv;
`else
   // The convergence flag is deliberately masked off in this build so that
   // every run executes the full requested iteration count.
   assign conv_exit = conv & 1'b0;
`endif

   // All state lives here. Reset is asynchronous so the controller drops
   // to IDLE with every output low the moment rstn_sctl falls, even in the
   // middle of a run.
   always_ff @(posedge clk_sctl or negedge rstn_sctl) begin
      if (!rstn_sctl) begin
         state    <= IDLE;
         iter_cnt <= '0;
         num_q    <= '0;
         wait_cnt <= '0;
         sel_fb   <= 1'b0;
      end else begin
         state    <= state_d;
         iter_cnt <= cnt_d;
         num_q    <= num_d;
         wait_cnt <= wait_d;
         sel_fb   <= sel_d;
      end
   end

   // Next-state and Moore outputs. Enables depend only on the current state,
   // so an abort takes effect on the following cycle. An abort in CHECK
   // still counts that iteration, because its update was already latched
   // in the preceding WAIT.
   always_comb begin
      state_d = state;
      cnt_d   = iter_cnt;
      num_d   = num_q;
      wait_d  = wait_cnt;
      en_mul4 = 1'b0;
      en_upd  = 1'b0;
      done    = 1'b0;
      busy    = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               cnt_d   = '0;
               num_d   = iter_num;
               state_d = (iter_num != '0) ? MUL : DONE;
            end
         end
         MUL: begin
            en_mul4 = 1'b1;
            wait_d  = 4'(UPD_LAT);
            state_d = abort ? IDLE : WAIT;
         end
         WAIT: begin
            en_upd = (wait_cnt == 4'd1);
            if (abort) begin
               state_d = IDLE;
            end else if (wait_cnt == 4'd1) begin
               state_d = CHECK;
            end else begin
               wait_d = wait_cnt - 4'd1;
            end
         end
         CHECK: begin
            cnt_d = cnt_inc;
            if (abort) begin
               state_d = IDLE;
            end else if ((cnt_inc == num_q) || conv_exit) begin
               state_d = DONE;
            end else begin
               state_d = MUL;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // The source select is registered when an iteration is entered and held
   // through its MUL and WAIT cycles. The first iteration of a run reads
   // the external W, and later iterations read the fed-back W. Outside
   // MUL/WAIT the select rests at 0.
   always_comb begin
      case (state_d)
         MUL:     sel_d = (cnt_d != '0);
         WAIT:    sel_d = sel_fb;
         default: sel_d = 1'b0;
      endcase
   end

endmodule

// File: doc/symm_ctrl.md
SYMM_CTRL -- requirements
Module: symm_ctrl

Interface
REQ-001 Parameter: ITER_W, default 4, width of iteration-count fields.
REQ-002 Parameter: UPD_LAT, default 2, range 1..15; cycles from the multiply-enable cycle's result to the update-register latch.
REQ-003 clk_sctl  input  1  sole clock; all state changes on rising edge.
REQ-004 rstn_sctl  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one orthogonalization run; sampled in IDLE only.
REQ-006 abort  input  1  terminate the run in progress.
REQ-007 iter_num  input  ITER_W  requested iteration count; captured at accepted start.
REQ-008 conv  input  1  convergence flag from external comparator; sampled in CHECK.
REQ-009 en_mul4  output  1  enable to the 4x4 W*W^T multiplier; one cycle per iteration.
REQ-010 sel_fb  output  1  multiplier source select: 0 = external W, 1 = fed-back updated W.
REQ-011 en_upd  output  1  latch enable for the W update register (1.5W - 0.5*(W*W^T)*W).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 iter_cnt  output  ITER_W  completed iterations of current or last run.

Function
REQ-015 The FSM SHALL have the states IDLE, MUL, WAIT, CHECK and DONE.
REQ-016 IDLE: start=1 with iter_num!=0 -> capture iter_num, clear iter_cnt, go to MUL. With iter_num=0 -> clear iter_cnt, go to DONE with no en_mul4.
REQ-017 MUL: en_mul4=1 for exactly this cycle; sel_fb=0 when iter_cnt=0, else 1; load wait counter; go to WAIT.
REQ-018 WAIT: remain UPD_LAT cycles; en_upd=1 only in the last WAIT cycle; then go to CHECK.
REQ-019 CHECK: iter_cnt increments by 1; go to DONE if the incremented value equals captured iter_num (or on early exit per REQ-028), else go to MUL.
REQ-020 DONE: done=1 for one cycle, then go to IDLE; iter_cnt holds its value until the next accepted start.
REQ-021 Timing: with start accepted at cycle 0 and N iterations, done SHALL assert at cycle 1+N*(UPD_LAT+2).
REQ-022 sel_fb SHALL be stable (registered) throughout MUL and WAIT of an iteration and 0 in IDLE.
REQ-023 start while busy SHALL be ignored; iter_num changes while busy SHALL have no effect.
REQ-024 abort=1 in MUL, WAIT or CHECK -> IDLE next cycle; no done and no further en_mul4/en_upd; iter_cnt retains completed count. abort in IDLE/DONE is ignored; DONE still pulses.
REQ-025 abort and start both high in IDLE: start SHALL be accepted (abort has no effect in IDLE).
REQ-026 iter_num = all-ones SHALL run 2^ITER_W-1 iterations with no counter wrap.

Reset
REQ-027 rstn_sctl low SHALL force immediately state IDLE, en_mul4=0, sel_fb=0, en_upd=0, busy=0, done=0, iter_cnt=0 and clear the captured iter_num and wait counter, including mid-run; operation resumes on the first rising edge after deassertion.

Configuration
REQ-028 With macro SYMM_CTRL_CONV_EN defined, conv=1 in CHECK SHALL force DONE regardless of iter_cnt; without it, conv SHALL be ignored and every run executes exactly iter_num iterations.

Verification
REQ-029 UPD_LAT=2, start with iter_num=1 -> en_mul4 at cycle 1 with sel_fb=0, en_upd at cycle 3, done at cycle 5, iter_cnt=1.
REQ-030 iter_num=3 -> en_mul4 at cycles 1,5,9 (sel_fb 0,1,1), done at cycle 13, iter_cnt=3.
REQ-031 iter_num=0 -> done at cycle 1, no en_mul4/en_upd, iter_cnt=0.
REQ-032 iter_num=5, abort at cycle 6 -> busy low from cycle 7, no done, iter_cnt=1; a second start during the run is ignored.
REQ-033 With SYMM_CTRL_CONV_EN, iter_num=8, conv=1 at second CHECK -> done at cycle 9, iter_cnt=2; without the macro, same stimulus -> done at cycle 33, iter_cnt=8.
REQ-034 rstn_sctl pulsed low during WAIT -> all outputs 0 asynchronously; fresh start afterwards reproduces REQ-029 timing.
